// File: rtl/token_packer_pkg.sv
// ============================================================================
// token_packer_pkg : shared state encoding and character classes
// Rev 1.0
// ============================================================================
`default_nettype none

package token_packer_pkg;

    localparam int CHAR_BITS = 8;

    localparam logic [CHAR_BITS-1:0] c_CHAR_SP  = 8'h20;
    localparam logic [CHAR_BITS-1:0] c_CHAR_CR  = 8'h0D;
    localparam logic [CHAR_BITS-1:0] c_CHAR_LF  = 8'h0A;
    localparam logic [CHAR_BITS-1:0] c_LEGAL_LO = 8'h21;
    localparam logic [CHAR_BITS-1:0] c_LEGAL_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    function automatic logic is_delim(input logic [CHAR_BITS-1:0] c);
        return (c == c_CHAR_SP) || (c == c_CHAR_CR) || (c == c_CHAR_LF);
    endfunction

    function automatic logic is_legal(input logic [CHAR_BITS-1:0] c);
        return (c >= c_LEGAL_LO) && (c <= c_LEGAL_HI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/token_timeout_ctr.sv
// ============================================================================
// token_timeout_ctr : idle-cycle counter, expires on the last allowed idle cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module token_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    // Count starts at 0 on the first idle cycle, so the (TIMEOUT_CYCLES-1)th idle cycle sees TIMEOUT_CYCLES-2.
    localparam logic [W-1:0] c_LAST = W'(TIMEOUT_CYCLES - 2);

    logic [W-1:0] cnt_q;

    assign o_expire = i_en && !i_clr && (cnt_q == c_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/token_packer.sv
// ============================================================================
// token_packer : packs ASCII chars into fixed-width tokens split on delimiters
// Rev 1.0
// ============================================================================
`default_nettype none

module token_packer
    import token_packer_pkg::*;
#(
    parameter int O_A_NUM_BITS   = 24,
    parameter int I_U_NUM_BITS   = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_char_vld,
    input  logic [CHAR_BITS-1:0]    i_char,
    output logic                    o_char_rdy,
    input  logic [I_U_NUM_BITS-1:0] i_u,
    output logic                    o_rdy,
    output logic [O_A_NUM_BITS-1:0] o_a,
    output logic [I_U_NUM_BITS-1:0] o_u,
    output logic                    o_trunc,
    output logic                    o_err
);

    localparam logic [7:0] c_N_CHARS = 8'(O_A_NUM_BITS / CHAR_BITS);

    state_t                  state_q;
    logic [O_A_NUM_BITS-1:0] tok_q;
    logic [7:0]              cnt_q;
    logic [I_U_NUM_BITS-1:0] u_tok_q;
    logic                    char_rdy_q;
    logic                    rdy_q;
    logic                    err_q;
    logic                    trunc_q;
    logic [O_A_NUM_BITS-1:0] a_q;
    logic [I_U_NUM_BITS-1:0] u_q;

    logic                    w_accept;
    logic                    w_delim;
    logic                    w_legal;
    logic [O_A_NUM_BITS-1:0] w_tok_shift;
    logic [7:0]              w_cnt_inc;
    logic                    w_timer_en;
    logic                    w_timer_clr;
    logic                    w_expire;

    assign w_accept    = i_char_vld && char_rdy_q;
    assign w_delim     = is_delim(i_char);
    assign w_legal     = is_legal(i_char);
    // Oldest chars fall off the top, leaving the rightmost N chars.
    assign w_tok_shift = (tok_q << CHAR_BITS) | O_A_NUM_BITS'(i_char);
    assign w_cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign w_timer_en  = (state_q == ST_ACCUM) && !w_accept;
    assign w_timer_clr = (state_q != ST_ACCUM) || w_accept;

    token_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_clr    (w_timer_clr),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            tok_q      <= '0;
            cnt_q      <= '0;
            u_tok_q    <= '0;
            char_rdy_q <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            trunc_q    <= 1'b0;
            a_q        <= '0;
            u_q        <= '0;
        end else begin
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            char_rdy_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept && w_legal) begin
                        tok_q   <= w_tok_shift;
                        cnt_q   <= 8'd1;
                        u_tok_q <= i_u;
                        state_q <= ST_ACCUM;
                    end else if (w_accept && !w_delim) begin
                        err_q <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept && w_legal) begin
                        tok_q <= w_tok_shift;
                        cnt_q <= w_cnt_inc;
                    end else if (w_accept && !w_delim) begin
                        err_q <= 1'b1;
                    end
                    if ((w_accept && w_delim) || w_expire) begin
                        state_q    <= ST_EMIT;
                        rdy_q      <= 1'b1;
                        a_q        <= tok_q;
                        u_q        <= u_tok_q;
                        trunc_q    <= (cnt_q > c_N_CHARS);
                        char_rdy_q <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    state_q <= ST_IDLE;
                    tok_q   <= '0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_char_rdy = char_rdy_q;
    assign o_rdy      = rdy_q;
    assign o_err      = err_q;
    assign o_trunc    = trunc_q;
    assign o_a        = a_q;
    assign o_u        = u_q;

endmodule

`default_nettype wire

// File: tb/tb_token_packer.sv
// ============================================================================
// tb_token_packer : directed self-checking bench for token_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_token_packer;

    localparam int W  = 24;
    localparam int U  = 4;
    localparam int TC = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vld = 1'b0;
    logic [7:0]   ch = 8'h00;
    logic [U-1:0] uin = '0;
    logic         o_char_rdy;
    logic         o_rdy;
    logic [W-1:0] o_a;
    logic [U-1:0] o_u;
    logic         o_trunc;
    logic         o_err;

    token_packer #(
        .O_A_NUM_BITS  (W),
        .I_U_NUM_BITS  (U),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_char_vld(vld),
        .i_char    (ch),
        .o_char_rdy(o_char_rdy),
        .i_u       (uin),
        .o_rdy     (o_rdy),
        .o_a       (o_a),
        .o_u       (o_u),
        .o_trunc   (o_trunc),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           rdy_cnt = 0;
    int           err_cnt = 0;
    int           rdy_cyc = 0;
    int           err_cyc = 0;
    logic [W-1:0] last_a = '0;
    logic [U-1:0] last_u = '0;
    logic         last_trunc = 1'b0;

    always @(negedge clk) begin
        if (o_rdy === 1'b1) begin
            rdy_cnt    <= rdy_cnt + 1;
            rdy_cyc    <= cyc;
            last_a     <= o_a;
            last_u     <= o_u;
            last_trunc <= o_trunc;
        end
        if (o_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic send(input logic [7:0] c, input logic [U-1:0] uu, output int pres);
        int n;
        n = 0;
        @(negedge clk);
        vld = 1'b1;
        ch  = c;
        uin = uu;
        while (o_char_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL send_accept char=%h o_char_rdy=%b expected 1", c, o_char_rdy);
        end
        pres = cyc;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        vld = 1'b0;
        ch  = 8'h00;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_neg(2);
        checks++;
        if (o_char_rdy !== 1'b0) begin errors++; $display("FAIL reset_char_rdy got %b expected 0", o_char_rdy); end
        checks++;
        if (o_rdy !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL reset_strobes rdy=%b err=%b expected 0 0", o_rdy, o_err); end
        checks++;
        if (o_a !== '0 || o_u !== '0 || o_trunc !== 1'b0) begin
            errors++; $display("FAIL reset_data a=%h u=%h trunc=%b expected 0 0 0", o_a, o_u, o_trunc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_neg(1);
        checks++;
        if (o_char_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_char_rdy got %b expected 1", o_char_rdy); end
    endtask

    task automatic test_buy();
        int b, d, sp;
        b = rdy_cnt;
        send(8'h42, 4'd1, d);
        send(8'h75, 4'd1, d);
        send(8'h79, 4'd1, d);
        send(8'h20, 4'd1, sp);
        idle();
        wait_neg(3);
        checks++;
        if (rdy_cnt - b != 1) begin errors++; $display("FAIL buy_rdy_count got %0d expected 1", rdy_cnt - b); end
        checks++;
        if (rdy_cyc != sp + 1) begin errors++; $display("FAIL buy_latency got %0d expected %0d", rdy_cyc - sp, 1); end
        checks++;
        if (last_a !== 24'h427579 || last_trunc !== 1'b0) begin
            errors++; $display("FAIL buy_token a=%h trunc=%b expected 427579 0", last_a, last_trunc);
        end
        checks++;
        if (o_a !== 24'h427579 || o_u !== 4'd1) begin errors++; $display("FAIL buy_hold a=%h u=%h expected 427579 1", o_a, o_u); end
    endtask

    task automatic test_truncate();
        int b, d;
        b = rdy_cnt;
        send(8'h41, 4'd3, d);
        send(8'h64, 4'd7, d);
        send(8'h64, 4'd7, d);
        send(8'h49, 4'd7, d);
        send(8'h74, 4'd7, d);
        send(8'h65, 4'd7, d);
        send(8'h6D, 4'd7, d);
        send(8'h0D, 4'd7, d);
        idle();
        wait_neg(3);
        checks++;
        if (rdy_cnt - b != 1) begin errors++; $display("FAIL trunc_rdy_count got %0d expected 1", rdy_cnt - b); end
        checks++;
        if (last_a !== 24'h74656D) begin errors++; $display("FAIL trunc_token got %h expected 74656d", last_a); end
        checks++;
        if (last_u !== 4'd3) begin errors++; $display("FAIL trunc_user got %0d expected 3", last_u); end
        checks++;
        if (last_trunc !== 1'b1) begin errors++; $display("FAIL trunc_flag got %b expected 1", last_trunc); end
    endtask

    task automatic test_timeout();
        int b, d, m, n;
        b = rdy_cnt;
        send(8'h41, 4'd5, d);
        send(8'h64, 4'd5, d);
        send(8'h6D, 4'd5, m);
        idle();
        n = 0;
        while (rdy_cnt == b && n < TC + 6) begin
            wait_neg(1);
            n++;
        end
        wait_neg(2);
        checks++;
        if (rdy_cnt - b != 1) begin errors++; $display("FAIL timeout_rdy_count got %0d expected 1", rdy_cnt - b); end
        checks++;
        if (rdy_cyc - m != TC) begin errors++; $display("FAIL timeout_latency got %0d expected %0d", rdy_cyc - m, TC); end
        checks++;
        if (last_a !== 24'h41646D || last_trunc !== 1'b0) begin
            errors++; $display("FAIL timeout_token a=%h trunc=%b expected 41646d 0", last_a, last_trunc);
        end
    endtask

    task automatic test_illegal();
        int b, be, d, e;
        b  = rdy_cnt;
        be = err_cnt;
        send(8'h20, 4'd2, d);
        send(8'h20, 4'd2, d);
        send(8'h41, 4'd2, d);
        send(8'h07, 4'd2, e);
        send(8'h62, 4'd2, d);
        send(8'h0A, 4'd2, d);
        idle();
        wait_neg(3);
        checks++;
        if (err_cnt - be != 1) begin errors++; $display("FAIL illegal_err_count got %0d expected 1", err_cnt - be); end
        checks++;
        if (err_cyc != e + 1) begin errors++; $display("FAIL illegal_err_cycle got %0d expected %0d", err_cyc, e + 1); end
        checks++;
        if (rdy_cnt - b != 1) begin errors++; $display("FAIL illegal_rdy_count got %0d expected 1", rdy_cnt - b); end
        checks++;
        if (last_a !== 24'h004162) begin errors++; $display("FAIL illegal_token got %h expected 004162", last_a); end
    endtask

    task automatic test_reset_mid();
        int b, d;
        b = rdy_cnt;
        send(8'h4C, 4'd4, d);
        send(8'h6F, 4'd4, d);
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_char_rdy !== 1'b0) begin errors++; $display("FAIL midreset_char_rdy got %b expected 0", o_char_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h67, 4'd4, d);
        send(8'h20, 4'd4, d);
        idle();
        wait_neg(3);
        checks++;
        if (rdy_cnt - b != 1) begin errors++; $display("FAIL midreset_rdy_count got %0d expected 1", rdy_cnt - b); end
        checks++;
        if (last_a !== 24'h000067) begin errors++; $display("FAIL midreset_token got %h expected 000067", last_a); end
    endtask

    task automatic test_back_to_back();
        int b, d;
        b = rdy_cnt;
        send(8'h58, 4'd6, d);
        send(8'h59, 4'd6, d);
        send(8'h20, 4'd6, d);
        @(negedge clk);
        vld = 1'b1;
        ch  = 8'h5A;
        uin = 4'd9;
        #1;
        checks++;
        if (o_char_rdy !== 1'b0 || o_rdy !== 1'b1) begin
            errors++; $display("FAIL emit_stall char_rdy=%b rdy=%b expected 0 1", o_char_rdy, o_rdy);
        end
        checks++;
        if (last_a !== 24'h005859) begin errors++; $display("FAIL b2b_first_token got %h expected 005859", last_a); end
        @(negedge clk);
        #1;
        checks++;
        if (o_char_rdy !== 1'b1) begin errors++; $display("FAIL emit_release char_rdy=%b expected 1", o_char_rdy); end
        @(posedge clk);
        send(8'h20, 4'd9, d);
        idle();
        wait_neg(3);
        checks++;
        if (rdy_cnt - b != 2) begin errors++; $display("FAIL b2b_rdy_count got %0d expected 2", rdy_cnt - b); end
        checks++;
        if (last_a !== 24'h00005A || last_u !== 4'd9) begin
            errors++; $display("FAIL b2b_second_token a=%h u=%h expected 00005a 9", last_a, last_u);
        end
    endtask

    initial begin
        test_reset();
        test_buy();
        test_truncate();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/token_packer.md
TOKEN_PACKER -- requirements
Module: token_packer

Interface
REQ-001 SHALL have parameter O_A_NUM_BITS, default 24, meaning packed token width (integer multiple of 8; 3 chars at default).
REQ-002 SHALL have parameter I_U_NUM_BITS, default 4, meaning user-number width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles inside a token before auto-emit (>=2).
REQ-004 SHALL have port i_clk  in  1  meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_reset_n  in  1  meaning reset, asynchronous, active-low.
REQ-006 SHALL have port i_char_vld  in  1  meaning i_char is valid this cycle.
REQ-007 SHALL have port i_char  in  8  meaning ASCII character.
REQ-008 SHALL have port o_char_rdy  out  1  meaning the block accepts i_char this cycle; a transfer occurs when vld&rdy.
REQ-009 SHALL have port i_u  in  I_U_NUM_BITS  meaning the user number, sampled with the first char of a token.
REQ-010 SHALL have port o_rdy  out  1  meaning one-cycle strobe that o_a/o_u hold a complete token (drives downstream i_rdy).
REQ-011 SHALL have port o_a  out  O_A_NUM_BITS  meaning the packed token, last char in bits [7:0].
REQ-012 SHALL have port o_u  out  I_U_NUM_BITS  meaning the user number latched for the token.
REQ-013 SHALL have port o_trunc  out  1  meaning the emitted token exceeded O_A_NUM_BITS/8 chars.
REQ-014 SHALL have port o_err  out  1  meaning one-cycle strobe that an illegal char was dropped.

Function
REQ-015 SHALL have states IDLE (no chars held), ACCUM (>=1 char held) and EMIT (token presented).
REQ-016 Delimiters are 0x20, 0x0D and 0x0A; legal chars are 0x21..0x7E; every other value is illegal.
REQ-017 An accepted legal char SHALL shift left into the token register (o_a-width, new char in [7:0], oldest bits dropped), increment the char count (8-bit, saturating at 255) and enter or remain in ACCUM.
REQ-018 The token register SHALL therefore hold the rightmost N chars, so "AddItem" packs as "tem", matching the downstream width-truncated literal compare.
REQ-019 On the first char of a token, the block SHALL latch i_u into the token user register.
REQ-020 A delimiter accepted in ACCUM SHALL move the block to EMIT on the next edge; a delimiter in IDLE SHALL be consumed with no effect (empty tokens are never emitted).
REQ-021 An illegal char SHALL be consumed and dropped, SHALL pulse o_err for 1 cycle, and SHALL leave the state and the token unchanged.
REQ-022 In ACCUM, the idle timer SHALL count cycles without an accepted char; at TIMEOUT_CYCLES-1, the block SHALL enter EMIT as if a delimiter had arrived.
REQ-023 A char accepted in the cycle the timer would expire SHALL win: the char is packed and the timer restarts at 0.
REQ-024 EMIT SHALL last exactly 1 cycle: o_rdy=1, o_a=token, o_u=latched user, o_trunc=(count>N); the next state is IDLE and the token, count and timer are cleared.
REQ-025 o_char_rdy SHALL be 1 in IDLE and ACCUM and 0 in EMIT; latency from the delimiter transfer to o_rdy SHALL be 1 cycle, and the throughput 1 token per (chars+2) cycles.
REQ-026 Between strobes, o_a, o_u and o_trunc SHALL hold the last emitted values.

Reset
REQ-027 While i_reset_n=0, the block SHALL hold state=IDLE; o_rdy=0, o_err=0, o_trunc=0, o_a=0, o_u=0, o_char_rdy=0, and the count, timer and token = 0.
REQ-028 Reset asserted mid-token SHALL discard the partial token, with no o_rdy emitted; accepting chars SHALL resume on the first edge after deassertion.

Structure
REQ-029 The shared package SHALL hold the state encoding, the delimiter and legal-range char constants, and CHAR_BITS=8.
REQ-030 The idle timer SHALL be one sub-module, token_timeout_ctr (clear, enable, expire output, width $clog2(TIMEOUT_CYCLES)).

Verification
REQ-031 Send "Buy",0x20 back-to-back -> o_rdy=1 for 1 cycle, 1 cycle after the space; o_a=0x427579, o_trunc=0.
REQ-032 Send "AddItem",0x0D with i_u=3 at 'A' and i_u=7 afterwards -> o_a=0x74656D ("tem"), o_u=3, o_trunc=1.
REQ-033 Send "Adm", then idle -> o_rdy exactly TIMEOUT_CYCLES cycles after 'm' is accepted, o_a=0x41646D.
REQ-034 Send 0x20,0x20,"A",0x07,"b",0x0A -> o_err one pulse at 0x07, a single o_rdy with o_a=0x004162, and no strobe for the leading spaces.
REQ-035 Send "Lo", then pull i_reset_n low for 1 cycle, then "g",0x20 -> a single o_rdy with o_a=0x000067, and no token containing "Lo".
REQ-036 Send a char with vld=1 during EMIT -> o_char_rdy=0 and the char is held until the next cycle, then accepted and packed into the next token.
